cog_accumulator_mc: RTL and testbench



---
 rtl/cog_accumulator_mc.sv | 232 +++++++++++++++++++++++
 tb/tb_cog_accumulator_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cog_accumulator_mc.sv
// Centre-of-gravity accumulator: per-figure sum(w), sum(w*coord), pixel count and
// start point, with a 4-stage arithmetic pipeline and a first-word-fall-through result FIFO.
module cog_accumulator_mc #(
    parameter int DATA_WIDTH     = 8,
    parameter int COORD_WIDTH    = 11,
    parameter int CNT_WIDTH      = 11,
    parameter int MIN_FIG_PIXELS = 3,
    parameter int MAX_FIG_PIXELS = 100,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              i_sys_clk,
    input  logic                              i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0]             i_data_image,
    input  logic                              i_data_valid,
    input  logic                              i_start_of_fig,
    input  logic                              i_end_of_fig,
    input  logic [COORD_WIDTH-1:0]            i_start_point_value,
    input  logic                              i_weight_mode,
    input  logic [DATA_WIDTH-1:0]             i_threshold,
    output logic                              o_res_valid,
    input  logic                              i_res_ready,
    output logic [2*DATA_WIDTH+CNT_WIDTH-1:0]   o_res_sum_i,
    output logic [2*DATA_WIDTH+2*CNT_WIDTH-1:0] o_res_sum_ic,
    output logic [CNT_WIDTH-1:0]              o_res_pixels,
    output logic [COORD_WIDTH-1:0]            o_res_start_point,
    output logic                              o_fig_rejected,
    output logic                              o_fig_aborted,
    output logic                              o_overflow
);
    localparam int W_W   = 2 * DATA_WIDTH;
    localparam int P_W   = W_W + CNT_WIDTH;
    localparam int SI_W  = W_W + CNT_WIDTH;
    localparam int SIC_W = W_W + 2 * CNT_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_C   = CNT_WIDTH'(MIN_FIG_PIXELS);
    localparam logic [CNT_WIDTH-1:0] MAX_C   = CNT_WIDTH'(MAX_FIG_PIXELS);
    localparam logic [AW:0]          FULL_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_IN_FIG} state_t;

    typedef struct packed {
        logic [SI_W-1:0]        sum_i;
        logic [SIC_W-1:0]       sum_ic;
        logic [CNT_WIDTH-1:0]   pixels;
        logic [COORD_WIDTH-1:0] sp;
    } res_t;

    state_t state_q, state_d;
    logic [CNT_WIDTH-1:0]   fig_cnt_q, fig_cnt_d;
    logic                   mode_q, mode_d;
    logic [DATA_WIDTH-1:0]  thr_q, thr_d;
    logic [COORD_WIDTH-1:0] sp_q, sp_d;
    logic                   aborted_q, aborted_d;

    logic                   eff_mode;
    logic [DATA_WIDTH-1:0]  eff_thr, i_prime;
    logic [W_W-1:0]         ip_ext;

    logic                   s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [W_W-1:0]         s1_w_q, s1_w_d;
    logic [CNT_WIDTH-1:0]   s1_coord_q, s1_coord_d, s1_cnt_q, s1_cnt_d;
    logic [COORD_WIDTH-1:0] s1_sp_q, s1_sp_d;

    logic                   s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic [W_W-1:0]         s2_w_q, s2_w_d;
    logic [P_W-1:0]         s2_prod_q, s2_prod_d;
    logic [CNT_WIDTH-1:0]   s2_cnt_q, s2_cnt_d;
    logic [COORD_WIDTH-1:0] s2_sp_q, s2_sp_d;

    logic                   s3_vld_q, s3_vld_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
    logic [W_W-1:0]         s3_w_q, s3_w_d;
    logic [P_W-1:0]         s3_prod_q, s3_prod_d;
    logic [CNT_WIDTH-1:0]   s3_cnt_q, s3_cnt_d;
    logic [COORD_WIDTH-1:0] s3_sp_q, s3_sp_d;

    logic [SI_W-1:0]        acc_i_q, acc_i_d;
    logic [SIC_W-1:0]       acc_ic_q, acc_ic_d;
    logic [CNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
    logic [COORD_WIDTH-1:0] acc_sp_q, acc_sp_d;
    logic                   acc_close_q, acc_close_d;

    logic                   cl_vld_q, cl_vld_d, cl_ok_q, cl_ok_d;
    res_t                   cl_res_q, cl_res_d;

    res_t                   mem_q [FIFO_DEPTH];
    res_t                   mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            fifo_cnt_q, fifo_cnt_d;
    logic                   rejected_q, rejected_d, overflow_q, overflow_d;
    logic                   full, pop, push_req, push;

    // Mode and threshold of the start pixel come straight from the inputs.
    always_comb begin
        state_d    = state_q;
        fig_cnt_d  = fig_cnt_q;
        mode_d     = mode_q;
        thr_d      = thr_q;
        sp_d       = sp_q;
        aborted_d  = 1'b0;
        s1_vld_d   = 1'b0;
        s1_first_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_coord_d = '0;
        s1_cnt_d   = '0;
        eff_mode   = i_start_of_fig ? i_weight_mode : mode_q;
        eff_thr    = i_start_of_fig ? i_threshold : thr_q;
        i_prime    = (i_data_image > eff_thr) ? (i_data_image - eff_thr) : '0;
        ip_ext     = {{DATA_WIDTH{1'b0}}, i_prime};
        s1_w_d     = eff_mode ? (ip_ext * ip_ext) : ip_ext;
        s1_sp_d    = i_start_of_fig ? i_start_point_value : sp_q;
        if (i_data_valid) begin
            if (i_start_of_fig) begin
                aborted_d  = (state_q == ST_IN_FIG);
                mode_d     = i_weight_mode;
                thr_d      = i_threshold;
                sp_d       = i_start_point_value;
                fig_cnt_d  = CNT_WIDTH'(1);
                s1_vld_d   = 1'b1;
                s1_first_d = 1'b1;
                s1_last_d  = i_end_of_fig;
                s1_cnt_d   = CNT_WIDTH'(1);
                state_d    = i_end_of_fig ? ST_IDLE : ST_IN_FIG;
            end else if (state_q == ST_IN_FIG) begin
                s1_coord_d = fig_cnt_q;
                s1_cnt_d   = (fig_cnt_q == CNT_MAX) ? fig_cnt_q : fig_cnt_q + CNT_WIDTH'(1);
                fig_cnt_d  = s1_cnt_d;
                s1_vld_d   = 1'b1;
                s1_last_d  = i_end_of_fig;
                if (i_end_of_fig) state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_w_d     = s1_w_q;
        s2_prod_d  = {{CNT_WIDTH{1'b0}}, s1_w_q} * {{W_W{1'b0}}, s1_coord_q};
        s2_cnt_d   = s1_cnt_q;
        s2_sp_d    = s1_sp_q;
        s3_vld_d   = s2_vld_q;
        s3_first_d = s2_first_q;
        s3_last_d  = s2_last_q;
        s3_w_d     = s2_w_q;
        s3_prod_d  = s2_prod_q;
        s3_cnt_d   = s2_cnt_q;
        s3_sp_d    = s2_sp_q;
        acc_i_d     = acc_i_q;
        acc_ic_d    = acc_ic_q;
        acc_cnt_d   = acc_cnt_q;
        acc_sp_d    = acc_sp_q;
        acc_close_d = 1'b0;
        // First-pixel load lets a new figure follow a closing one with no gap.
        if (s3_vld_q) begin
            acc_i_d     = (s3_first_q ? '0 : acc_i_q) + {{(SI_W - W_W){1'b0}}, s3_w_q};
            acc_ic_d    = (s3_first_q ? '0 : acc_ic_q) + {{(SIC_W - P_W){1'b0}}, s3_prod_q};
            acc_cnt_d   = s3_cnt_q;
            acc_sp_d    = s3_sp_q;
            acc_close_d = s3_last_q;
        end
        cl_vld_d        = acc_close_q;
        cl_ok_d         = (acc_cnt_q >= MIN_C) && (acc_cnt_q <= MAX_C);
        cl_res_d.sum_i  = acc_i_q;
        cl_res_d.sum_ic = acc_ic_q;
        cl_res_d.pixels = acc_cnt_q;
        cl_res_d.sp     = acc_sp_q;
    end

    always_comb begin
        full       = (fifo_cnt_q == FULL_C);
        pop        = o_res_valid && i_res_ready;
        push_req   = cl_vld_q && cl_ok_q;
        push       = push_req && (!full || pop);
        rejected_d = cl_vld_q && !cl_ok_q;
        overflow_d = push_req && !push;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = cl_res_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q <= ST_IDLE;
            fig_cnt_q <= '0; mode_q <= 1'b0; thr_q <= '0; sp_q <= '0; aborted_q <= 1'b0;
            s1_vld_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
            s1_w_q <= '0; s1_coord_q <= '0; s1_cnt_q <= '0; s1_sp_q <= '0;
            s2_vld_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
            s2_w_q <= '0; s2_prod_q <= '0; s2_cnt_q <= '0; s2_sp_q <= '0;
            s3_vld_q <= 1'b0; s3_first_q <= 1'b0; s3_last_q <= 1'b0;
            s3_w_q <= '0; s3_prod_q <= '0; s3_cnt_q <= '0; s3_sp_q <= '0;
            acc_i_q <= '0; acc_ic_q <= '0; acc_cnt_q <= '0; acc_sp_q <= '0; acc_close_q <= 1'b0;
            cl_vld_q <= 1'b0; cl_ok_q <= 1'b0; cl_res_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0; rd_ptr_q <= '0; fifo_cnt_q <= '0;
            rejected_q <= 1'b0; overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fig_cnt_q <= fig_cnt_d; mode_q <= mode_d; thr_q <= thr_d; sp_q <= sp_d; aborted_q <= aborted_d;
            s1_vld_q <= s1_vld_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
            s1_w_q <= s1_w_d; s1_coord_q <= s1_coord_d; s1_cnt_q <= s1_cnt_d; s1_sp_q <= s1_sp_d;
            s2_vld_q <= s2_vld_d; s2_first_q <= s2_first_d; s2_last_q <= s2_last_d;
            s2_w_q <= s2_w_d; s2_prod_q <= s2_prod_d; s2_cnt_q <= s2_cnt_d; s2_sp_q <= s2_sp_d;
            s3_vld_q <= s3_vld_d; s3_first_q <= s3_first_d; s3_last_q <= s3_last_d;
            s3_w_q <= s3_w_d; s3_prod_q <= s3_prod_d; s3_cnt_q <= s3_cnt_d; s3_sp_q <= s3_sp_d;
            acc_i_q <= acc_i_d; acc_ic_q <= acc_ic_d; acc_cnt_q <= acc_cnt_d; acc_sp_q <= acc_sp_d;
            acc_close_q <= acc_close_d;
            cl_vld_q <= cl_vld_d; cl_ok_q <= cl_ok_d; cl_res_q <= cl_res_d;
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fifo_cnt_q <= fifo_cnt_d;
            rejected_q <= rejected_d; overflow_q <= overflow_d;
        end
    end

    assign o_res_valid       = (fifo_cnt_q != '0);
    assign o_res_sum_i       = mem_q[rd_ptr_q].sum_i;
    assign o_res_sum_ic      = mem_q[rd_ptr_q].sum_ic;
    assign o_res_pixels      = mem_q[rd_ptr_q].pixels;
    assign o_res_start_point = mem_q[rd_ptr_q].sp;
    assign o_fig_rejected    = rejected_q;
    assign o_fig_aborted     = aborted_q;
    assign o_overflow        = overflow_q;
endmodule

// File: tb/tb_cog_accumulator_mc.sv
// Directed bench for cog_accumulator_mc: a table of 3-pixel figures plus
// hand-written sequences for reject, back-to-back, abort, backpressure and reset.
module tb_cog_accumulator_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  img = '0;
    logic        dvalid = 1'b0, sof = 1'b0, eof = 1'b0;
    logic [10:0] spv = '0;
    logic        wmode = 1'b0;
    logic [7:0]  thr = '0;
    logic        res_valid, res_ready = 1'b0;
    logic [26:0] sum_i;
    logic [37:0] sum_ic;
    logic [10:0] pixels, start_pt;
    logic        rejected, aborted, overflow;

    int checks = 0;
    int failures = 0;
    int rej_cnt = 0, abt_cnt = 0, ovf_cnt = 0;

    cog_accumulator_mc dut (
        .i_sys_clk(clk), .i_sys_aresetn(rst_n),
        .i_data_image(img), .i_data_valid(dvalid),
        .i_start_of_fig(sof), .i_end_of_fig(eof),
        .i_start_point_value(spv), .i_weight_mode(wmode), .i_threshold(thr),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_sum_i(sum_i), .o_res_sum_ic(sum_ic),
        .o_res_pixels(pixels), .o_res_start_point(start_pt),
        .o_fig_rejected(rejected), .o_fig_aborted(aborted), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rejected) rej_cnt++;
        if (aborted)  abt_cnt++;
        if (overflow) ovf_cnt++;
    end

    typedef struct {
        logic        mode;
        logic [7:0]  thr;
        logic [10:0] sp;
        logic [7:0]  p0, p1, p2;
        longint      exp_i;
        longint      exp_ic;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pixel(input logic [7:0] v, input logic s, input logic e,
                         input logic [10:0] p, input logic m, input logic [7:0] t);
        @(negedge clk);
        img = v; sof = s; eof = e; spv = p; wmode = m; thr = t; dvalid = 1'b1;
        @(posedge clk);
        #1;
        dvalid = 1'b0; sof = 1'b0; eof = 1'b0;
    endtask

    task automatic send_fig(input int n, input logic [7:0] v, input logic m,
                            input logic [7:0] t, input logic [10:0] p);
        for (int i = 0; i < n; i++) pixel(v, i == 0, i == n - 1, p, m, t);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic chk_head(input string name, input longint ei, input longint eic,
                            input longint ep, input longint es);
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_sum_i"}, sum_i, ei);
        chk({name, "_sum_ic"}, sum_ic, eic);
        chk({name, "_pixels"}, pixels, ep);
        chk({name, "_start"}, start_pt, es);
    endtask

    int lat;
    int r0, a0, o0;

    initial begin
        vecs[0] = '{1'b1, 8'd0,   11'd100,  8'd10,  8'd20,  8'd30,  1400,  2200};
        vecs[1] = '{1'b0, 8'd15,  11'd100,  8'd10,  8'd20,  8'd30,  20,    35};
        vecs[2] = '{1'b1, 8'd5,   11'd7,    8'd5,   8'd6,   8'd255, 62501, 125001};
        vecs[3] = '{1'b0, 8'd0,   11'd2047, 8'd255, 8'd255, 8'd255, 765,   765};
        vecs[4] = '{1'b1, 8'd255, 11'd5,    8'd255, 8'd200, 8'd1,   0,     0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", res_valid, 0);
        chk("reset_sum_i", sum_i, 0);
        chk("reset_pulses", {rejected, aborted, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            pixel(vecs[v].p0, 1'b1, 1'b0, vecs[v].sp, vecs[v].mode, vecs[v].thr);
            pixel(vecs[v].p1, 1'b0, 1'b0, 11'd0, 1'b0, 8'd0);
            pixel(vecs[v].p2, 1'b0, 1'b1, 11'd0, 1'b0, 8'd0);
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", v), lat, 5);
            chk_head($sformatf("vec%0d", v), vecs[v].exp_i, vecs[v].exp_ic, 3, vecs[v].sp);
            pop_one();
            chk($sformatf("vec%0d_empty", v), res_valid, 0);
        end

        // Out-of-range figures: 1, 2 and 101 pixels rejected, 100 accepted.
        r0 = rej_cnt;
        send_fig(1, 8'd9, 1'b0, 8'd0, 11'd1);
        send_fig(2, 8'd9, 1'b0, 8'd0, 11'd2);
        send_fig(101, 8'd1, 1'b0, 8'd0, 11'd3);
        repeat (10) @(posedge clk);
        #1;
        chk("reject_count", rej_cnt - r0, 3);
        chk("reject_no_entry", res_valid, 0);
        send_fig(100, 8'd1, 1'b0, 8'd0, 11'd4);
        wait_valid(lat);
        chk("max_latency", lat, 5);
        chk_head("max100", 100, 4950, 100, 4);
        pop_one();

        // Back-to-back: B starts the cycle after A ends.
        send_fig(3, 8'd1, 1'b0, 8'd0, 11'd10);
        send_fig(3, 8'd2, 1'b1, 8'd0, 11'd20);
        repeat (10) @(posedge clk);
        #1;
        chk_head("b2b_A", 3, 3, 3, 10);
        pop_one();
        chk_head("b2b_B", 12, 12, 3, 20);
        pop_one();
        chk("b2b_empty", res_valid, 0);

        // Abort: restart inside an open figure.
        a0 = abt_cnt; r0 = rej_cnt;
        pixel(8'd5, 1'b1, 1'b0, 11'd50, 1'b0, 8'd0);
        pixel(8'd5, 1'b0, 1'b0, 11'd0, 1'b0, 8'd0);
        send_fig(3, 8'd3, 1'b0, 8'd0, 11'd60);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_count", abt_cnt - a0, 1);
        chk("abort_no_reject", rej_cnt - r0, 0);
        chk_head("abort_restart", 9, 9, 3, 60);
        pop_one();
        chk("abort_single_entry", res_valid, 0);

        // Backpressure: five figures into a 4-deep FIFO.
        o0 = ovf_cnt;
        for (int k = 1; k <= 5; k++) send_fig(3, 8'(k), 1'b0, 8'd0, 11'(200 + k));
        repeat (10) @(posedge clk);
        #1;
        chk("overflow_count", ovf_cnt - o0, 1);
        chk_head("bp_hold", 3, 3, 3, 201);

        // Full FIFO: a pop in the close cycle frees the slot for the new result.
        send_fig(3, 8'd6, 1'b0, 8'd0, 11'd206);
        repeat (4) @(posedge clk);
        pop_one();
        repeat (3) @(posedge clk);
        #1;
        chk("push_with_pop_no_ovf", ovf_cnt - o0, 1);
        begin
            int exp_k[4];
            exp_k = '{2, 3, 4, 6};
            @(negedge clk);
            res_ready = 1'b1;
            for (int j = 0; j < 4; j++) begin
                chk_head($sformatf("drain%0d", j), 3 * exp_k[j], 3 * exp_k[j], 3, 200 + exp_k[j]);
                @(negedge clk);
            end
            res_ready = 1'b0;
            chk("drain_empty", res_valid, 0);
        end

        // Reset with a stored result and a partial figure in flight.
        send_fig(3, 8'd7, 1'b0, 8'd0, 11'd300);
        wait_valid(lat);
        pixel(8'd9, 1'b1, 1'b0, 11'd400, 1'b0, 8'd0);
        pixel(8'd9, 1'b0, 1'b0, 11'd0, 1'b0, 8'd0);
        r0 = rej_cnt; a0 = abt_cnt; o0 = ovf_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_sum_i", sum_i, 0);
        chk("rst_sum_ic", sum_ic, 0);
        chk("rst_pixels_start", {pixels, start_pt}, 0);
        chk("rst_pulses", {rejected, aborted, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_pulses", (rej_cnt - r0) + (abt_cnt - a0) + (ovf_cnt - o0), 0);
        chk("rst_still_empty", res_valid, 0);
        pixel(8'd10, 1'b1, 1'b0, 11'd100, 1'b1, 8'd0);
        pixel(8'd20, 1'b0, 1'b0, 11'd0, 1'b0, 8'd0);
        pixel(8'd30, 1'b0, 1'b1, 11'd0, 1'b0, 8'd0);
        wait_valid(lat);
        chk("post_rst_latency", lat, 5);
        chk_head("post_rst", 1400, 2200, 3, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
